set_assoc_dcache: RTL
=====================

Name: set_assoc_dcache

Overview:
Parametrised N-way set-associative, write-through data cache. It sits between the memory-stage pipeline register and data RAM, and replaces the fixed two-way cache. It adds a stall handshake, a memory-side request/acknowledge interface, byte-enable writes, round-robin replacement, flush and hit/miss counters. The `stall_o` output drives the pipeline enable, with `en_progression` equal to `~stall_o`.

Parameters:
- DW, 32, data/word width in bits; must be a multiple of 8.
- AW, 32, byte-address width.
- SETS, 4, number of sets; power of 2, ≥2.
- WAYS, 2, associativity; power of 2, 1..8.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_i  in  1  CPU access valid.
- we_i  in  1  1 = store, 0 = load.
- addr_i  in  AW  byte address; low log2(DW/8) bits ignored.
- wdata_i  in  DW  store data.
- wstrb_i  in  DW/8  store byte enables.
- flush_i  in  1  invalidate all lines.
- rdata_o  out  DW  load data.
- stall_o  out  1  CPU must hold its request.
- mem_req_o  out  1  memory transaction request.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  AW  word-aligned memory address.
- mem_wdata_o  out  DW  memory write data.
- mem_be_o  out  DW/8  memory byte enables.
- mem_rdata_i  in  DW  memory read data.
- mem_ack_i  in  1  single-cycle completion strobe.
- hit_count_o  out  CNT_W  load/store hits, saturating.
- miss_count_o  out  CNT_W  load/store misses, saturating.

Behaviour:
- Clocking: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Line size: one word per line.
- Address split:
  - offset = low OB = log2(DW/8) bits.
  - index = next log2(SETS) bits.
  - tag = remaining upper bits.
- Storage per way/set: valid bit, tag, data. There is one round-robin victim pointer per set, log2(WAYS) bits, or 0 bits when WAYS=1.
- Reset:
  - All valid bits cleared, victim pointers 0, counters 0, state IDLE.
  - `mem_req_o`=0, `mem_we_o`=0, `stall_o`=0, `rdata_o`=0.
  - Reset mid-transaction abandons the memory transaction; any late `mem_ack_i` in IDLE is ignored.
- States: IDLE, REFILL, WRITE.
- IDLE, load hit:
  - Combinational lookup.
  - `rdata_o` = hit way data in the same cycle, `stall_o`=0, hit counter +1.
- IDLE, load miss:
  - `stall_o`=1 in the same cycle; miss counter +1.
  - Address is latched and the state moves to REFILL.
- IDLE, store (hit or miss):
  - `stall_o`=1; address, data and strobes are latched; state moves to WRITE.
  - Hit/miss is counted in the IDLE cycle.
- REFILL:
  - `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o` = latched address with offset zeroed.
  - Request is held stable until `mem_ack_i`.
  - On the ack cycle:
    - Victim way = first invalid way (lowest index); otherwise the set's pointer.
    - Victim is written with valid=1, tag, `mem_rdata_i`.
    - Pointer increments modulo WAYS only when a valid line was evicted.
    - `rdata_o` = `mem_rdata_i`, `stall_o`=0 (combinational from `mem_ack_i`).
    - Next state IDLE. The CPU request is consumed that cycle.
- WRITE:
  - `mem_req_o`=1, `mem_we_o`=1, `mem_wdata_o` = latched data, `mem_be_o` = latched strobes; held stable until ack.
  - On the ack cycle:
    - If the latched address hits, only the enabled bytes of that way are updated.
    - A store miss does not allocate.
    - `stall_o`=0, next state IDLE.
- Outside REFILL/WRITE: `mem_req_o`=0; `mem_*` data outputs are don't-care but stable.
- Flush:
  - Honoured only in IDLE; clears all valid bits in one cycle. Victim pointers are kept.
  - If `req_i` coincides, flush wins: `stall_o`=1 that cycle and the request is evaluated next cycle against the empty cache.
  - `flush_i` in REFILL/WRITE is ignored; the CPU must hold it.
- Counters: saturate at 2^CNT_W−1, no wrap.
- `req_i`=0 in IDLE: `stall_o`=0, no state change, `rdata_o` holds its last value.

Test Plan (SETS=4, WAYS=2, DW=32; index = addr[3:2]):
1. Read miss then hit.
   - Stimulus: after reset, load 0x100; memory acks 3 cycles after request with 0xDEADBEEF; then load 0x100 again.
   - Required: `stall_o`=1 in the first cycle; `mem_req_o`=1 with `mem_addr_o`=0x100 until ack; `rdata_o`=0xDEADBEEF with `stall_o`=0 on the ack cycle. Second load hits in one cycle, `stall_o`=0. Final counts: hit=1, miss=1.
2. Round-robin eviction.
   - Stimulus: load 0x100, 0x200, 0x300 (all set 0), then 0x300, then 0x100.
   - Required: 0x300 evicts 0x100 (way 0, pointer→1). Load 0x300 hits; load 0x100 misses and evicts 0x200.
3. Byte-strobe write-through.
   - Stimulus: with 0x100 cached as 0xDEADBEEF, store 0x100 with `wdata_i`=0x000000AA, `wstrb_i`=0001.
   - Required: `mem_we_o`=1, `mem_be_o`=0001 until ack; a subsequent load 0x100 hits with 0xDEADBEAA.
4. No-allocate store.
   - Stimulus: store 0x404 (miss), then load 0x404.
   - Required: memory write issued; miss_count increments for both accesses; the load issues REFILL.
5. Flush.
   - Stimulus: after filling 0x100 and 0x110, pulse `flush_i` together with a load of 0x100.
   - Required: `stall_o`=1 in the flush cycle; the next-cycle load misses and `mem_req_o` rises.
6. Reset mid-miss and counter saturation.
   - Stimulus: assert `rst` during REFILL, then ack late; separately, with CNT_W=2, perform 5 hits.
   - Required: after reset, `mem_req_o`=0, `stall_o`=0, counters 0, and the late ack has no effect. The 2-bit hit_count saturates at 3.

Source files
------------

// File: rtl/set_assoc_dcache.sv
// N-way set-associative write-through data cache, one word per line.
// Round-robin replacement, byte-strobe stores, no-allocate on store miss.
module set_assoc_dcache #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int SETS  = 4,
  parameter int WAYS  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic [DW/8-1:0]  wstrb_i,
  input  logic             flush_i,
  output logic [DW-1:0]    rdata_o,
  output logic             stall_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [DW-1:0]    mem_wdata_o,
  output logic [DW/8-1:0]  mem_be_o,
  input  logic [DW-1:0]    mem_rdata_i,
  input  logic             mem_ack_i,
  output logic [CNT_W-1:0] hit_count_o,
  output logic [CNT_W-1:0] miss_count_o
);

  localparam int NB = DW / 8;
  localparam int OB = (NB > 1) ? $clog2(NB) : 1;
  localparam int IB = $clog2(SETS);
  localparam int TW = AW - OB - IB;
  localparam int PW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;

  state_e state_q, state_d;

  logic [WAYS-1:0] valid_q [SETS];
  logic [TW-1:0]   tag_q   [SETS][WAYS];
  logic [DW-1:0]   data_q  [SETS][WAYS];
  logic [PW-1:0]   ptr_q   [SETS];

  logic [AW-1:OB]  addr_q;
  logic [DW-1:0]   wdata_q;
  logic [NB-1:0]   wstrb_q;
  logic [DW-1:0]   rdata_q;
  logic [CNT_W-1:0] hit_q, miss_q;

  logic            unused_off;
  logic [IB-1:0]   idx;
  logic [TW-1:0]   tag;
  logic            hit;
  logic [PW-1:0]   hit_way;
  logic [DW-1:0]   hit_data;
  logic [PW-1:0]   vic;
  logic            vic_free;
  logic [PW-1:0]   ptr_nxt;

  logic hit_inc, miss_inc;
  logic do_flush, do_latch, do_fill, do_wr;

  assign unused_off = ^addr_i[OB-1:0];

  // Lookup uses the live address in IDLE, the latched one while busy
  assign idx = (state_q == IDLE) ? addr_i[OB+:IB] : addr_q[OB+:IB];
  assign tag = (state_q == IDLE) ? addr_i[AW-1-:TW] : addr_q[AW-1-:TW];

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit      = 1'b1;
        hit_way  = PW'(w);
        hit_data = data_q[idx][w];
      end
    end
  end

  always_comb begin
    vic      = ptr_q[idx];
    vic_free = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_q[idx][w] && !vic_free) begin
        vic      = PW'(w);
        vic_free = 1'b1;
      end
    end
    ptr_nxt = (ptr_q[idx] == PW'(WAYS - 1)) ? '0 : ptr_q[idx] + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    stall_o   = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    rdata_o   = rdata_q;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    do_flush  = 1'b0;
    do_latch  = 1'b0;
    do_fill   = 1'b0;
    do_wr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          do_flush = 1'b1;
          stall_o  = req_i;
        end else if (req_i) begin
          hit_inc  = hit;
          miss_inc = !hit;
          if (we_i) begin
            stall_o  = 1'b1;
            do_latch = 1'b1;
            state_d  = WRITE;
          end else if (hit) begin
            rdata_o = hit_data;
          end else begin
            stall_o  = 1'b1;
            do_latch = 1'b1;
            state_d  = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
        if (mem_ack_i) begin
          stall_o = 1'b0;
          rdata_o = mem_rdata_i;
          do_fill = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        stall_o   = 1'b1;
        if (mem_ack_i) begin
          stall_o = 1'b0;
          do_wr   = hit;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr_o   = {addr_q, {OB{1'b0}}};
  assign mem_wdata_o  = wdata_q;
  assign mem_be_o     = wstrb_q;
  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_o;
      if (hit_inc && hit_q != '1)
        hit_q <= hit_q + 1'b1;
      if (miss_inc && miss_q != '1)
        miss_q <= miss_q + 1'b1;
      if (do_flush) begin
        for (int s = 0; s < SETS; s++)
          valid_q[s] <= '0;
      end
      if (do_fill) begin
        valid_q[idx][vic] <= 1'b1;
        if (!vic_free)
          ptr_q[idx] <= ptr_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_latch) begin
      addr_q  <= addr_i[AW-1:OB];
      wdata_q <= wdata_i;
      wstrb_q <= wstrb_i;
    end
    if (do_fill) begin
      tag_q[idx][vic]  <= tag;
      data_q[idx][vic] <= mem_rdata_i;
    end
    if (do_wr) begin
      for (int b = 0; b < NB; b++)
        if (wstrb_q[b])
          data_q[idx][hit_way][b*8+:8] <= wdata_q[b*8+:8];
    end
  end

endmodule
